cv32e40px_x_arbiter: RTL and testbench

- Sits between the core's single X-interface master port and NUM_COPROC coprocessor slave ports.
- Broadcasts issue requests to all coprocessors and records which coprocessor accepted each instruction ID in a 16-entry ownership table.
- Routes commit transactions only to the coprocessor that owns the ID.
- Arbitrates the coprocessors' result channels back onto the core's single result channel, round-robin. Operand and result data muxing lives outside this block, driven by result_sel_o.

---
 rtl/cv32e40px_x_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_cv32e40px_x_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40px_x_arbiter.sv
// X-interface arbiter: broadcasts issue to NUM_COPROC coprocessors, tracks
// instruction ownership by ID, routes commits, round-robins result channels.
module cv32e40px_x_arbiter #(
    parameter int unsigned NUM_COPROC      = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                x_issue_valid_i,
    output logic                                x_issue_ready_o,
    input  logic [3:0]                          x_issue_req_id_i,
    output logic                                x_issue_resp_accept_o,
    output logic                                x_issue_resp_writeback_o,
    input  logic                                x_commit_valid_i,
    input  logic [3:0]                          x_commit_id_i,
    input  logic                                x_commit_kill_i,
    output logic                                x_result_valid_o,
    input  logic                                x_result_ready_i,
    output logic [3:0]                          x_result_id_o,
    output logic [4:0]                          x_result_rd_o,
    output logic                                x_result_we_o,
    output logic [$clog2(NUM_COPROC)-1:0]       result_sel_o,
    output logic [NUM_COPROC-1:0]               cop_issue_valid_o,
    input  logic [NUM_COPROC-1:0]               cop_issue_ready_i,
    input  logic [NUM_COPROC-1:0]               cop_issue_resp_accept_i,
    input  logic [NUM_COPROC-1:0]               cop_issue_resp_writeback_i,
    output logic [NUM_COPROC-1:0]               cop_commit_valid_o,
    input  logic [NUM_COPROC-1:0]               cop_result_valid_i,
    output logic [NUM_COPROC-1:0]               cop_result_ready_o,
    input  logic [NUM_COPROC-1:0][3:0]          cop_result_id_i,
    input  logic [NUM_COPROC-1:0][4:0]          cop_result_rd_i,
    input  logic [NUM_COPROC-1:0]               cop_result_we_i,
    output logic [4:0]                          outstanding_o,
    output logic                                err_o
);

    localparam int unsigned SW = $clog2(NUM_COPROC);

    logic [15:0]                  tv_q, tv_d;
    logic [15:0][SW-1:0]          to_q, to_d;
    logic [NUM_COPROC-1:0][3:0]   cnt_q, cnt_d;
    logic [SW-1:0]                ptr_q, ptr_d;
    logic [SW-1:0]                gnt_q, gnt_d;
    logic                         lock_q, lock_d;
    logic                         err_q, err_d;

    logic                         stall;
    logic [NUM_COPROC-1:0]        avail;
    logic [NUM_COPROC-1:0]        acc;
    logic [SW-1:0]                iss_own;
    logic                         multi;
    logic                         issue_fire;

    logic                         cmt_hit;
    logic [SW-1:0]                cmt_own;
    logic                         kill;

    logic                         found;
    logic [SW-1:0]                arb_idx;
    logic [SW-1:0]                cand;
    logic [SW-1:0]                grant;
    logic [3:0]                   rid;
    logic                         res_fire;
    logic                         res_own;
    logic [5:0]                   cnt_nxt;

    // Issue side: stall on an ID already in flight, mask full coprocessors
    always_comb begin
        stall = tv_q[x_issue_req_id_i];
        for (int i = 0; i < int'(NUM_COPROC); i++) begin
            avail[i] = cnt_q[i] < 4'(MAX_OUTSTANDING);
        end
        cop_issue_valid_o = {NUM_COPROC{x_issue_valid_i & ~stall}} & avail;
        x_issue_ready_o   = ~stall & (&(cop_issue_ready_i | ~avail));
        acc               = cop_issue_valid_o & cop_issue_resp_accept_i;
        iss_own           = '0;
        for (int i = int'(NUM_COPROC) - 1; i >= 0; i--) begin
            if (acc[i]) iss_own = SW'(i);
        end
        multi      = (acc & (acc - 1'b1)) != '0;
        issue_fire = x_issue_valid_i & x_issue_ready_o & (|acc);
        x_issue_resp_accept_o    = |acc;
        x_issue_resp_writeback_o = (|acc) & cop_issue_resp_writeback_i[iss_own];
    end

    always_comb begin
        cmt_hit = x_commit_valid_i & tv_q[x_commit_id_i];
        cmt_own = to_q[x_commit_id_i];
        kill    = cmt_hit & x_commit_kill_i;
        for (int i = 0; i < int'(NUM_COPROC); i++) begin
            cop_commit_valid_o[i] = cmt_hit & (cmt_own == SW'(i));
        end
    end

    // Round-robin search starting at the pointer, wrapping around
    always_comb begin
        found   = 1'b0;
        arb_idx = ptr_q;
        cand    = '0;
        for (int k = 0; k < int'(NUM_COPROC); k++) begin
            cand = SW'((int'(ptr_q) + k) % int'(NUM_COPROC));
            if (!found && cop_result_valid_i[cand]) begin
                found   = 1'b1;
                arb_idx = cand;
            end
        end
        grant              = lock_q ? gnt_q : arb_idx;
        x_result_valid_o   = lock_q ? cop_result_valid_i[gnt_q] : found;
        x_result_id_o      = cop_result_id_i[grant];
        x_result_rd_o      = cop_result_rd_i[grant];
        x_result_we_o      = cop_result_we_i[grant];
        result_sel_o       = grant;
        cop_result_ready_o = '0;
        cop_result_ready_o[grant] = x_result_ready_i & x_result_valid_o;
        res_fire = x_result_valid_o & x_result_ready_i;
        rid      = cop_result_id_i[grant];
        res_own  = tv_q[rid] & (to_q[rid] == grant);
    end

    always_comb begin
        tv_d   = tv_q;
        to_d   = to_q;
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        gnt_d  = gnt_q;
        lock_d = lock_q;
        cnt_nxt = '0;
        err_d  = err_q | (issue_fire & multi)
                       | (x_commit_valid_i & ~tv_q[x_commit_id_i])
                       | (res_fire & ~res_own);
        if (kill) tv_d[x_commit_id_i] = 1'b0;
        if (res_fire && res_own) tv_d[rid] = 1'b0;
        if (issue_fire) begin
            tv_d[x_issue_req_id_i] = 1'b1;
            to_d[x_issue_req_id_i] = iss_own;
        end
        // Counter delta is +issue -kill -result, saturating at 0..15
        for (int i = 0; i < int'(NUM_COPROC); i++) begin
            cnt_nxt = {2'b00, cnt_q[i]};
            if (issue_fire && iss_own == SW'(i)) cnt_nxt = cnt_nxt + 6'd1;
            if (kill && cmt_own == SW'(i))       cnt_nxt = cnt_nxt - 6'd1;
            if (res_fire && res_own && grant == SW'(i)) cnt_nxt = cnt_nxt - 6'd1;
            if (cnt_nxt[5])      cnt_d[i] = 4'd0;
            else if (cnt_nxt[4]) cnt_d[i] = 4'd15;
            else                 cnt_d[i] = cnt_nxt[3:0];
        end
        if (x_result_valid_o && !x_result_ready_i) begin
            lock_d = 1'b1;
            gnt_d  = grant;
        end else if (res_fire) begin
            lock_d = 1'b0;
            ptr_d  = (grant == SW'(NUM_COPROC - 1)) ? '0 : grant + SW'(1);
        end
    end

    always_comb begin
        outstanding_o = '0;
        for (int k = 0; k < 16; k++) begin
            outstanding_o = outstanding_o + 5'(tv_q[k]);
        end
    end

    assign err_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tv_q   <= '0;
            to_q   <= '0;
            cnt_q  <= '0;
            ptr_q  <= '0;
            gnt_q  <= '0;
            lock_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            tv_q   <= tv_d;
            to_q   <= to_d;
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
            lock_q <= lock_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_cv32e40px_x_arbiter.sv
// Bench for cv32e40px_x_arbiter: issue vector table, result scoreboard,
// hand-written sequences for stall, lock, saturation, error and reset.
module tb_cv32e40px_x_arbiter;

    localparam int N = 2;

    logic             clk_i, rst_ni;
    logic             x_issue_valid_i, x_issue_ready_o;
    logic [3:0]       x_issue_req_id_i;
    logic             x_issue_resp_accept_o, x_issue_resp_writeback_o;
    logic             x_commit_valid_i, x_commit_kill_i;
    logic [3:0]       x_commit_id_i;
    logic             x_result_valid_o, x_result_ready_i;
    logic [3:0]       x_result_id_o;
    logic [4:0]       x_result_rd_o;
    logic             x_result_we_o;
    logic [0:0]       result_sel_o;
    logic [N-1:0]     cop_issue_valid_o, cop_issue_ready_i;
    logic [N-1:0]     cop_issue_resp_accept_i, cop_issue_resp_writeback_i;
    logic [N-1:0]     cop_commit_valid_o;
    logic [N-1:0]     cop_result_valid_i, cop_result_ready_o;
    logic [N-1:0][3:0] cop_result_id_i;
    logic [N-1:0][4:0] cop_result_rd_i;
    logic [N-1:0]     cop_result_we_i;
    logic [4:0]       outstanding_o;
    logic             err_o;

    cv32e40px_x_arbiter #(.NUM_COPROC(N), .MAX_OUTSTANDING(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .x_issue_valid_i(x_issue_valid_i), .x_issue_ready_o(x_issue_ready_o),
        .x_issue_req_id_i(x_issue_req_id_i),
        .x_issue_resp_accept_o(x_issue_resp_accept_o),
        .x_issue_resp_writeback_o(x_issue_resp_writeback_o),
        .x_commit_valid_i(x_commit_valid_i), .x_commit_id_i(x_commit_id_i),
        .x_commit_kill_i(x_commit_kill_i),
        .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
        .x_result_id_o(x_result_id_o), .x_result_rd_o(x_result_rd_o),
        .x_result_we_o(x_result_we_o), .result_sel_o(result_sel_o),
        .cop_issue_valid_o(cop_issue_valid_o), .cop_issue_ready_i(cop_issue_ready_i),
        .cop_issue_resp_accept_i(cop_issue_resp_accept_i),
        .cop_issue_resp_writeback_i(cop_issue_resp_writeback_i),
        .cop_commit_valid_o(cop_commit_valid_o),
        .cop_result_valid_i(cop_result_valid_i), .cop_result_ready_o(cop_result_ready_o),
        .cop_result_id_i(cop_result_id_i), .cop_result_rd_i(cop_result_rd_i),
        .cop_result_we_i(cop_result_we_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] id;
        logic [1:0] rdy, acc, wb;
        logic       e_rdy;
        logic [1:0] e_val;
        logic       e_acc, e_wb;
        logic [4:0] e_out;
    } vec_t;

    typedef struct {
        logic       sel;
        logic [3:0] id;
    } rexp_t;

    vec_t       vt[8];
    rexp_t      exp_q[$];
    logic [3:0] pend0[$];
    logic [3:0] pend1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr_inputs();
        x_issue_valid_i = 0; x_issue_req_id_i = 0;
        x_commit_valid_i = 0; x_commit_id_i = 0; x_commit_kill_i = 0;
        x_result_ready_i = 0;
        cop_issue_ready_i = 0; cop_issue_resp_accept_i = 0;
        cop_issue_resp_writeback_i = 0;
        cop_result_valid_i = 0; cop_result_id_i = '0;
        cop_result_rd_i = '0; cop_result_we_i = 0;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        clr_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1;
        cop_issue_ready_i = 2'b11;
        #1;
    endtask

    task automatic set_res(input int c, input logic v, input logic [3:0] id);
        cop_result_valid_i[c] = v;
        cop_result_id_i[c]    = id;
        cop_result_rd_i[c]    = 5'(id) + 5'd8;
        cop_result_we_i[c]    = id[0];
    endtask

    task automatic issue(input logic [3:0] id, input logic [1:0] acc, input logic [1:0] wb);
        x_issue_valid_i = 1; x_issue_req_id_i = id;
        cop_issue_resp_accept_i = acc; cop_issue_resp_writeback_i = wb;
    endtask

    task automatic issue_off();
        x_issue_valid_i = 0; cop_issue_resp_accept_i = 0;
        cop_issue_resp_writeback_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rexp_t e;
        int    budget;
        vt[0] = '{4'd3, 2'b11, 2'b10, 2'b10, 1'b1, 2'b11, 1'b1, 1'b1, 5'd1};
        vt[1] = '{4'd3, 2'b11, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 5'd1};
        vt[2] = '{4'd5, 2'b01, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 5'd1};
        vt[3] = '{4'd5, 2'b11, 2'b00, 2'b00, 1'b1, 2'b11, 1'b0, 1'b0, 5'd1};
        vt[4] = '{4'd5, 2'b11, 2'b01, 2'b00, 1'b1, 2'b11, 1'b1, 1'b0, 5'd2};
        vt[5] = '{4'd1, 2'b11, 2'b01, 2'b01, 1'b1, 2'b11, 1'b1, 1'b1, 5'd3};
        vt[6] = '{4'd2, 2'b11, 2'b10, 2'b00, 1'b1, 2'b11, 1'b1, 1'b0, 5'd4};
        vt[7] = '{4'd4, 2'b11, 2'b01, 2'b01, 1'b1, 2'b11, 1'b1, 1'b1, 5'd5};

        rst_ni = 0;
        clr_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst issue_ready", x_issue_ready_o, 0);
        chk("rst issue_valid", cop_issue_valid_o, 0);
        chk("rst result_valid", x_result_valid_o, 0);
        chk("rst result_ready", cop_result_ready_o, 0);
        chk("rst commit_valid", cop_commit_valid_o, 0);
        chk("rst outstanding", outstanding_o, 0);
        chk("rst err", err_o, 0);
        rst_ni = 1;
        cop_issue_ready_i = 2'b11;
        #1;

        for (int v = 0; v < 8; v++) begin
            x_issue_valid_i = 1; x_issue_req_id_i = vt[v].id;
            cop_issue_ready_i = vt[v].rdy;
            cop_issue_resp_accept_i = vt[v].acc;
            cop_issue_resp_writeback_i = vt[v].wb;
            #1;
            chk($sformatf("vec%0d ready", v), x_issue_ready_o, vt[v].e_rdy);
            chk($sformatf("vec%0d valid", v), cop_issue_valid_o, vt[v].e_val);
            chk($sformatf("vec%0d accept", v), x_issue_resp_accept_o, vt[v].e_acc);
            chk($sformatf("vec%0d wb", v), x_issue_resp_writeback_o, vt[v].e_wb);
            tick();
            issue_off();
            cop_issue_ready_i = 2'b11;
            #1;
            chk($sformatf("vec%0d outstanding", v), outstanding_o, vt[v].e_out);
        end

        x_commit_valid_i = 1; x_commit_id_i = 4'd3; #1;
        chk("commit id3", cop_commit_valid_o, 2'b10);
        x_commit_id_i = 4'd5; #1;
        chk("commit id5", cop_commit_valid_o, 2'b01);
        tick();
        x_commit_valid_i = 0; #1;
        chk("commit err", err_o, 0);

        // Round-robin scoreboard: cop0 owns 1,4 and cop1 owns 2,3
        pend0 = {4'd1, 4'd4};
        pend1 = {4'd2, 4'd3};
        exp_q.push_back('{1'b0, 4'd1});
        exp_q.push_back('{1'b1, 4'd2});
        exp_q.push_back('{1'b0, 4'd4});
        exp_q.push_back('{1'b1, 4'd3});
        budget = 0;
        x_result_ready_i = 1;
        while ((pend0.size() != 0 || pend1.size() != 0) && budget < 12) begin
            set_res(0, pend0.size() != 0, pend0.size() != 0 ? pend0[0] : 4'd0);
            set_res(1, pend1.size() != 0, pend1.size() != 0 ? pend1[0] : 4'd0);
            #1;
            if (x_result_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("rr unexpected result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rr sel", result_sel_o, e.sel);
                    chk("rr id", x_result_id_o, e.id);
                    chk("rr rd", x_result_rd_o, 5'(e.id) + 5'd8);
                    chk("rr we", x_result_we_o, e.id[0]);
                end
                if (cop_result_ready_o[0] && pend0.size() != 0) void'(pend0.pop_front());
                if (cop_result_ready_o[1] && pend1.size() != 0) void'(pend1.pop_front());
            end
            tick();
            budget++;
        end
        chk("rr drained", budget < 12, 1);
        chk("rr queue empty", exp_q.size(), 0);
        cop_result_valid_i = 0; x_result_ready_i = 0; #1;
        chk("rr outstanding", outstanding_o, 1);
        chk("rr err", err_o, 0);

        // Re-issue of ID 5 stalls while its result frees the entry
        issue(4'd5, 2'b01, 2'b00);
        set_res(0, 1, 4'd5);
        x_result_ready_i = 1;
        #1;
        chk("stall ready", x_issue_ready_o, 0);
        chk("stall valid", cop_issue_valid_o, 0);
        chk("stall res sel", result_sel_o, 0);
        tick();
        cop_result_valid_i = 0; x_result_ready_i = 0; #1;
        chk("unstall ready", x_issue_ready_o, 1);
        chk("unstall valid", cop_issue_valid_o, 2'b11);
        tick();
        issue_off(); #1;
        chk("unstall outstanding", outstanding_o, 1);

        // Pointer is now 1: lock must hold grant 0 once cop1 shows up
        set_res(0, 1, 4'd5);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) set_res(1, 1, 4'd2);
            #1;
            chk($sformatf("lock%0d sel", c), result_sel_o, 0);
            chk($sformatf("lock%0d valid", c), x_result_valid_o, 1);
            chk($sformatf("lock%0d rdy_o", c), cop_result_ready_o, 0);
            tick();
        end
        x_result_ready_i = 1; set_res(1, 0, 4'd0); #1;
        chk("lock rel sel", result_sel_o, 0);
        chk("lock rel id", x_result_id_o, 5);
        chk("lock rel rdy_o", cop_result_ready_o, 2'b01);
        tick();
        cop_result_valid_i = 0; x_result_ready_i = 0; #1;
        chk("lock outstanding", outstanding_o, 0);
        chk("lock err", err_o, 0);

        // Saturate cop0 at MAX_OUTSTANDING
        for (int k = 6; k < 10; k++) begin
            issue(4'(k), 2'b01, 2'b00); #1;
            chk($sformatf("fill%0d ready", k), x_issue_ready_o, 1);
            tick();
        end
        issue_off(); #1;
        chk("fill outstanding", outstanding_o, 4);
        issue(4'd10, 2'b11, 2'b10);
        cop_issue_ready_i = 2'b10; #1;
        chk("full valid", cop_issue_valid_o, 2'b10);
        chk("full ready", x_issue_ready_o, 1);
        chk("full accept", x_issue_resp_accept_o, 1);
        chk("full wb", x_issue_resp_writeback_o, 1);
        tick();
        cop_issue_ready_i = 2'b11;
        issue(4'd11, 2'b00, 2'b00);
        x_commit_valid_i = 1; x_commit_id_i = 4'd6; x_commit_kill_i = 1; #1;
        chk("kill commit", cop_commit_valid_o, 2'b01);
        chk("kill same-cycle valid", cop_issue_valid_o, 2'b10);
        tick();
        x_commit_valid_i = 0; x_commit_kill_i = 0; #1;
        chk("kill eligible", cop_issue_valid_o, 2'b11);
        chk("kill outstanding", outstanding_o, 4);
        chk("masked no err", err_o, 0);
        issue_off();

        // Mismatched result: cop1 reports ID 7 owned by cop0
        set_res(1, 1, 4'd7); x_result_ready_i = 1; #1;
        chk("mis fwd valid", x_result_valid_o, 1);
        chk("mis fwd sel", result_sel_o, 1);
        chk("mis fwd id", x_result_id_o, 7);
        tick();
        cop_result_valid_i = 0; x_result_ready_i = 0; #1;
        chk("mis err", err_o, 1);
        chk("mis table", outstanding_o, 4);
        tick();
        chk("mis err sticky", err_o, 1);

        do_reset();
        chk("reset err clr", err_o, 0);
        x_commit_valid_i = 1; x_commit_id_i = 4'd12; #1;
        chk("unowned commit", cop_commit_valid_o, 0);
        tick();
        x_commit_valid_i = 0; #1;
        chk("unowned err", err_o, 1);

        do_reset();
        issue(4'd11, 2'b11, 2'b10); #1;
        chk("dual accept", x_issue_resp_accept_o, 1);
        chk("dual wb owner0", x_issue_resp_writeback_o, 0);
        tick();
        issue_off(); #1;
        chk("dual err", err_o, 1);
        chk("dual outstanding", outstanding_o, 1);
        x_commit_valid_i = 1; x_commit_id_i = 4'd11; #1;
        chk("dual owner commit", cop_commit_valid_o, 2'b01);
        x_commit_valid_i = 0;

        // Reset in the middle of a locked grant
        set_res(0, 1, 4'd11); x_result_ready_i = 0;
        tick();
        chk("pre-rst lock valid", x_result_valid_o, 1);
        rst_ni = 0;
        clr_inputs(); #1;
        chk("mid-rst result_valid", x_result_valid_o, 0);
        chk("mid-rst rdy_o", cop_result_ready_o, 0);
        chk("mid-rst issue_ready", x_issue_ready_o, 0);
        chk("mid-rst outstanding", outstanding_o, 0);
        chk("mid-rst err", err_o, 0);
        tick();
        rst_ni = 1; cop_issue_ready_i = 2'b11;
        issue(4'd11, 2'b00, 2'b00);
        set_res(1, 1, 4'd2); #1;
        chk("post-rst issue ready", x_issue_ready_o, 1);
        chk("post-rst unlocked sel", result_sel_o, 1);
        chk("post-rst unlocked valid", x_result_valid_o, 1);
        issue_off(); cop_result_valid_i = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
